clock_reset_sequencer: RTL

Per-PLL lock supervisor and domain reset generator that sits directly downstream of the clock generation block. Watches the asynchronous LOCKED outputs of the main MMCM and the RAM PLL, drives their RST inputs, and produces one synchronous reset per clock family (main: 125/250/312.5/400/625 MHz; RAM: 375/187.5/93.75/250 MHz). Runs on a free-running clock that does not come from either PLL, so it keeps operating while a PLL is unlocked and its BUFGCE outputs are gated.

---
 rtl/clock_reset_sequencer.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/clock_reset_sequencer.sv
// -----------------------------------------------------------------------------
// clock_reset_sequencer
//
// Lock supervisor and domain reset generator for the main MMCM and the RAM PLL.
// Runs on a free-running clock that comes from neither PLL. Each channel
// resets its PLL, waits for LOCKED, demands a stable lock window, and only
// then releases the matching domain reset. A lock loss while running restarts
// the channel from the PLL reset.
//
// Optional feature macro: LOCK_LOSS_COUNTERS_EN
//   defined   -> per-channel saturating 8-bit lock-loss counters with clear
//   undefined -> counters not built, counts read 0, clear_counts ignored
//
// Parameters:
//   PLL_RST_CYCLES      cycles pll_*_rst is held per reset attempt (>= 1)
//   LOCK_TIMEOUT_CYCLES cycles allowed waiting for lock before re-resetting
//   LOCK_STABLE_CYCLES  consecutive lock-high cycles needed before release
//
// Ports:
//   clk              free-running supervisor clock
//   rst              synchronous active-high reset
//   pll_main_lock    async LOCKED from main MMCM
//   pll_ram_lock     async LOCKED from RAM PLL
//   clear_counts     single-cycle pulse, zeroes both loss counters
//   pll_main_rst     RST to main MMCM
//   pll_ram_rst      RST to RAM PLL
//   rst_main         active-high reset for main-PLL clock domains
//   rst_ram          active-high reset for RAM-PLL clock domains
//   ready            both channels running
//   main_loss_count  lock-loss events on main channel (saturating)
//   ram_loss_count   lock-loss events on RAM channel (saturating)
// -----------------------------------------------------------------------------
module clock_reset_sequencer #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_main_lock,
    input  logic       pll_ram_lock,
    input  logic       clear_counts,
    output logic       pll_main_rst,
    output logic       pll_ram_rst,
    output logic       rst_main,
    output logic       rst_ram,
    output logic       ready,
    output logic [7:0] main_loss_count,
    output logic [7:0] ram_loss_count
);

    // One counter serves every phase, so it is sized for the longest one.
    // Every terminal compare clears it, so it can never wrap.
    localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_P = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
    localparam int CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } chan_state_t;

    // Channel 0 = main MMCM, channel 1 = RAM PLL
    logic [1:0] lock_raw_s;
    logic [1:0] pll_rst_s;
    logic [1:0] dom_rst_s;
    logic [1:0] run_s;
    logic [7:0] loss_count_s [2];
    logic       ready_r;

    assign lock_raw_s = {pll_ram_lock, pll_main_lock};

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic             lock_meta_r;
        logic             lock_sync_r;
        chan_state_t      state_r;
        chan_state_t      state_next_s;
        logic [CNT_W-1:0] cnt_r;
        logic [CNT_W-1:0] cnt_next_s;
        logic             loss_s;
        logic             pll_rst_r;
        logic             dom_rst_r;

        // Two-flop synchronizer for the asynchronous LOCKED input
        always_ff @(posedge clk) begin
            if (rst) begin
                lock_meta_r <= 1'b0;
                lock_sync_r <= 1'b0;
            end else begin
                lock_meta_r <= lock_raw_s[ch];
                lock_sync_r <= lock_meta_r;
            end
        end

        // Next-state and phase counter logic for one channel
        always_comb begin
            state_next_s = state_r;
            cnt_next_s   = cnt_r;
            loss_s       = 1'b0;
            case (state_r)
                ST_PLL_RST: begin
                    if (cnt_r == RST_LAST) begin
                        state_next_s = ST_WAIT_LOCK;
                        cnt_next_s   = CNT_ZERO;
                    end else begin
                        cnt_next_s   = cnt_r + CNT_ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_sync_r) begin
                        state_next_s = ST_STABLE;
                        cnt_next_s   = CNT_ZERO;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        state_next_s = ST_PLL_RST;
                        cnt_next_s   = CNT_ZERO;
                    end else begin
                        cnt_next_s   = cnt_r + CNT_ONE;
                    end
                end
                ST_STABLE: begin
                    // Any dropout restarts the whole stability window
                    if (!lock_sync_r) begin
                        state_next_s = ST_WAIT_LOCK;
                        cnt_next_s   = CNT_ZERO;
                    end else if (cnt_r == STABLE_LAST) begin
                        state_next_s = ST_RUN;
                        cnt_next_s   = CNT_ZERO;
                    end else begin
                        cnt_next_s   = cnt_r + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (!lock_sync_r) begin
                        state_next_s = ST_PLL_RST;
                        cnt_next_s   = CNT_ZERO;
                        loss_s       = 1'b1;
                    end else begin
                        cnt_next_s   = CNT_ZERO;
                    end
                end
                default: begin
                    state_next_s = ST_PLL_RST;
                    cnt_next_s   = CNT_ZERO;
                end
            endcase
        end

        // State register plus registered PLL/domain resets (one cycle behind state)
        always_ff @(posedge clk) begin
            if (rst) begin
                state_r   <= ST_PLL_RST;
                cnt_r     <= CNT_ZERO;
                pll_rst_r <= 1'b1;
                dom_rst_r <= 1'b1;
            end else begin
                state_r   <= state_next_s;
                cnt_r     <= cnt_next_s;
                pll_rst_r <= (state_r == ST_PLL_RST);
                dom_rst_r <= (state_r != ST_RUN);
            end
        end

        assign pll_rst_s[ch] = pll_rst_r;
        assign dom_rst_s[ch] = dom_rst_r;
        assign run_s[ch]     = (state_r == ST_RUN);

`ifdef LOCK_LOSS_COUNTERS_EN
        logic [7:0] loss_cnt_r;

        // Saturating lock-loss counter; a coincident clear is applied before the increment
        always_ff @(posedge clk) begin
            if (rst) begin
                loss_cnt_r <= 8'd0;
            end else if (clear_counts) begin
                loss_cnt_r <= loss_s ? 8'd1 : 8'd0;
            end else if (loss_s && (loss_cnt_r != 8'hFF)) begin
                loss_cnt_r <= loss_cnt_r + 8'd1;
            end else begin
                loss_cnt_r <= loss_cnt_r;
            end
        end

        assign loss_count_s[ch] = loss_cnt_r;
`else
        logic unused_loss_s;
        assign unused_loss_s    = loss_s;
        assign loss_count_s[ch] = 8'd0;
`endif
    end

`ifndef LOCK_LOSS_COUNTERS_EN
    logic unused_clear_s;
    assign unused_clear_s = clear_counts;
`endif

    // Registered ready: both channel state registers in RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= &run_s;
        end
    end

    assign pll_main_rst    = pll_rst_s[0];
    assign pll_ram_rst     = pll_rst_s[1];
    assign rst_main        = dom_rst_s[0];
    assign rst_ram         = dom_rst_s[1];
    assign ready           = ready_r;
    assign main_loss_count = loss_count_s[0];
    assign ram_loss_count  = loss_count_s[1];

endmodule
